// File: rtl/adc_capture_ctrl.sv
`timescale 1ns/1ps
// Parallel-ADC sequencer: paces convst, waits out busy, strobes rd_n and
// averages 2^AVG_LOG2 captured words into one result with a valid strobe.
module adc_capture_ctrl #(
  parameter int unsigned PERIOD   = 100,
  parameter int unsigned CONVST_W = 2,
  parameter int unsigned RD_W     = 2,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        busy,
  input  logic [15:0] data_in,
  input  logic        clr_err,
  output logic        convst,
  output logic        rd_n,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W  = AVG_LOG2 + 1;
  localparam int unsigned AVG_N  = 1 << AVG_LOG2;
  localparam int unsigned TICK_W = $clog2(PERIOD);
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned PH_MAX = (CONVST_W > RD_W) ? CONVST_W : RD_W;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, READ, CAPT} state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                convst_q, convst_d;
  logic                rd_n_q, rd_n_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                sample_valid_q, sample_valid_d;
  logic                overrun_q, overrun_d;
  logic                timeout_err_q, timeout_err_d;

  logic                tick_c;
  logic                ovr_set_c;
  logic                to_set_c;
  logic [ACC_W-1:0]    acc_sum_c;

  // Sample pacing: counter is parked at 0 while disabled.
  always_comb begin
    tick_c = enable && (tick_cnt_q == TICK_W'(PERIOD - 1));
    if (!enable || tick_c) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end
  end

  assign acc_sum_c = acc_q + ACC_W'(data_in);

  always_comb begin
    state_d        = state_q;
    ph_d           = ph_q;
    to_d           = to_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    convst_d       = convst_q;
    rd_n_d         = rd_n_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    to_set_c       = 1'b0;
    ovr_set_c      = tick_c && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (tick_c) begin
          state_d  = START;
          convst_d = 1'b1;
          ph_d     = '0;
        end
      end
      START: begin
        if (ph_q == PH_W'(CONVST_W - 1)) begin
          state_d  = WAIT_HI;
          convst_d = 1'b0;
          to_d     = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      // One timeout budget spans both busy phases; a partial capture is dropped.
      WAIT_HI, WAIT_LO: begin
        if (state_q == WAIT_HI && busy) begin
          state_d = WAIT_LO;
          to_d    = to_q + TO_W'(1);
        end else if (state_q == WAIT_LO && !busy) begin
          state_d = READ;
          rd_n_d  = 1'b0;
          ph_d    = '0;
        end else if (to_q >= TO_W'(TIMEOUT - 1)) begin
          state_d  = IDLE;
          to_set_c = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      READ: begin
        if (ph_q == PH_W'(RD_W - 1)) begin
          state_d = CAPT;
          rd_n_d  = 1'b1;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      // data_in lags the ADC bus by one register, so it is taken a cycle after rd_n rises.
      CAPT: begin
        state_d = IDLE;
        if (cnt_q == CNT_W'(AVG_N - 1)) begin
          sample_d       = DATA_W'(acc_sum_c >> AVG_LOG2);
          sample_valid_d = 1'b1;
          acc_d          = '0;
          cnt_d          = '0;
        end else begin
          acc_d = acc_sum_c;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    overrun_d     = ovr_set_c | (overrun_q & ~clr_err);
    timeout_err_d = to_set_c | (timeout_err_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      tick_cnt_q     <= '0;
      ph_q           <= '0;
      to_q           <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      convst_q       <= 1'b0;
      rd_n_q         <= 1'b1;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      ph_q           <= ph_d;
      to_q           <= to_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      convst_q       <= convst_d;
      rd_n_q         <= rd_n_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign convst       = convst_q;
  assign rd_n         = rd_n_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench: default build (A) plus a PERIOD=16, no-averaging build (B),
// each driven by a simple ADC model fed from a per-conversion data queue.
module tb_adc_capture_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        en_a, busy_a, clr_a, convst_a, rd_n_a, valid_a, ovr_a, to_a;
  logic [15:0] din_a, sample_a;
  logic        en_b, busy_b, clr_b, convst_b, rd_n_b, valid_b, ovr_b, to_b;
  logic [15:0] din_b, sample_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] feed_a[$];
  logic [15:0] feed_b[$];
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  bit   stuck_a    = 1'b0;
  int   len_a      = 10;
  int   len_b      = 10;
  int   cv_rises_a = 0;
  int   cv_rises_b = 0;
  int   bcnt_a     = 0;
  int   bcnt_b     = 0;
  logic cvp_a      = 1'b0;
  logic cvp_b      = 1'b0;

  adc_capture_ctrl u_dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .busy(busy_a), .data_in(din_a),
    .clr_err(clr_a), .convst(convst_a), .rd_n(rd_n_a), .sample(sample_a),
    .sample_valid(valid_a), .overrun(ovr_a), .timeout_err(to_a)
  );

  adc_capture_ctrl #(.PERIOD(16), .AVG_LOG2(0)) u_dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .busy(busy_b), .data_in(din_b),
    .clr_err(clr_b), .convst(convst_b), .rd_n(rd_n_b), .sample(sample_b),
    .sample_valid(valid_b), .overrun(ovr_b), .timeout_err(to_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ADC models: busy rises right after convst and stays high len cycles.
  initial begin
    busy_a = 1'b0; din_a = 16'h0000;
    busy_b = 1'b0; din_b = 16'h0000;
  end

  always @(negedge clk) begin
    if (convst_a && !cvp_a) begin
      cv_rises_a++;
      if (!stuck_a) begin
        busy_a = 1'b1;
        bcnt_a = len_a;
        if (feed_a.size() > 0) din_a = feed_a.pop_front();
      end
    end else if (bcnt_a > 0) begin
      bcnt_a--;
      if (bcnt_a == 0) busy_a = 1'b0;
    end
    cvp_a = convst_a;
  end

  always @(negedge clk) begin
    if (convst_b && !cvp_b) begin
      cv_rises_b++;
      busy_b = 1'b1;
      bcnt_b = len_b;
      if (feed_b.size() > 0) din_b = feed_b.pop_front();
    end else if (bcnt_b > 0) begin
      bcnt_b--;
      if (bcnt_b == 0) busy_b = 1'b0;
    end
    cvp_b = convst_b;
  end

  // Scoreboard monitors
  always @(negedge clk) begin
    if (valid_a === 1'b1) begin
      if (exp_a.size() == 0) begin
        check("a_unexpected_valid", 32'(valid_a), 32'd0);
      end else begin
        automatic logic [15:0] e = exp_a.pop_front();
        check("a_sample", 32'(sample_a), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (valid_b === 1'b1) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected_valid", 32'(valid_b), 32'd0);
      end else begin
        automatic logic [15:0] e = exp_b.pop_front();
        check("b_sample", 32'(sample_b), 32'(e));
      end
    end
  end

  task automatic wait_rises(input bit is_a, input int target, input int budget, input string name);
    int n = 0;
    while (((is_a ? cv_rises_a : cv_rises_b) < target) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'((is_a ? cv_rises_a : cv_rises_b) >= target), 32'd1);
  endtask

  task automatic wait_exp(input bit is_a, input int budget, input string name);
    int n = 0;
    while (((is_a ? exp_a.size() : exp_b.size()) > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(is_a ? exp_a.size() : exp_b.size()), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    int n;
    reset = 1'b0;
    en_a = 1'b0; clr_a = 1'b0;
    en_b = 1'b0; clr_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_convst", 32'(convst_a), 32'd0);
    check("rst_rd_n", 32'(rd_n_a), 32'd1);
    check("rst_sample", 32'(sample_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_overrun", 32'(ovr_a), 32'd0);
    check("rst_timeout", 32'(to_a), 32'd0);
    check("rst_b_convst", 32'(convst_b), 32'd0);
    check("rst_b_rd_n", 32'(rd_n_b), 32'd1);
    reset = 1'b1;

    // B: no averaging, enable dropped during WAIT_LO of the third conversion
    len_b = 10;
    feed_b = {16'hABCD, 16'h0001, 16'hFFFF};
    exp_b  = {16'hABCD, 16'h0001, 16'hFFFF};
    r = cv_rises_b;
    @(negedge clk); en_b = 1'b1;
    wait_rises(1'b0, r + 3, 100, "b_three_starts");
    repeat (5) @(posedge clk);
    #1 en_b = 1'b0;
    repeat (60) @(posedge clk);
    check("b_no_start_after_disable", 32'(cv_rises_b), 32'(r + 3));
    check("b_all_samples_seen", 32'(exp_b.size()), 32'd0);

    // B: busy longer than PERIOD gives overrun and a dropped tick
    len_b = 20;
    feed_b.push_back(16'h1234);
    exp_b.push_back(16'h1234);
    r = cv_rises_b;
    @(negedge clk); en_b = 1'b1;
    wait_rises(1'b0, r + 1, 40, "b_first_start");
    #1 check("b_no_overrun_yet", 32'(ovr_b), 32'd0);
    repeat (19) @(posedge clk);
    #1 check("b_overrun_set", 32'(ovr_b), 32'd1);
    check("b_tick_dropped", 32'(cv_rises_b), 32'(r + 1));
    en_b = 1'b0;
    repeat (40) @(posedge clk);
    check("b_long_conv_sample", 32'(exp_b.size()), 32'd0);
    check("b_overrun_sticky", 32'(ovr_b), 32'd1);
    check("b_no_timeout", 32'(to_b), 32'd0);
    @(negedge clk); clr_b = 1'b1;
    @(negedge clk); clr_b = 1'b0;
    check("b_overrun_cleared", 32'(ovr_b), 32'd0);

    // A: start timing and three averaged words
    feed_a = {16'h1000, 16'h1000, 16'h1000, 16'h1000,
              16'h0001, 16'h0002, 16'h0003, 16'h0006,
              16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    exp_a  = {16'h1000, 16'h0003, 16'hFFFF};
    @(negedge clk); en_a = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!convst_a && n < 200);
    check("a_first_convst_clk", 32'(n), 32'd100);
    n = 0;
    do begin n++; @(posedge clk); #1; end while (convst_a && n < 10);
    check("a_convst_width", 32'(n), 32'd2);
    wait_exp(1'b1, 1500, "a_avg_results");
    check("a_no_overrun", 32'(ovr_a), 32'd0);
    check("a_no_timeout", 32'(to_a), 32'd0);

    // A: timeout mid-average keeps the accumulator, drops the partial capture
    feed_a = {16'h0010, 16'h0020};
    r = cv_rises_a;
    wait_rises(1'b1, r + 2, 300, "a_two_starts");
    repeat (30) @(posedge clk);
    stuck_a = 1'b1;
    wait_rises(1'b1, r + 3, 150, "a_stuck_start");
    n = 0;
    do begin @(posedge clk); #1; n++; end while (convst_a && n < 10);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!to_a && n < 100);
    check("a_timeout_clk", 32'(n), 32'd64);
    check("a_no_overrun_at_timeout", 32'(ovr_a), 32'd0);
    stuck_a = 1'b0;
    feed_a = {16'h0030, 16'h0040};
    exp_a.push_back(16'h0028);
    wait_exp(1'b1, 600, "a_avg_after_timeout");
    check("a_timeout_sticky", 32'(to_a), 32'd1);
    @(negedge clk); clr_a = 1'b1;
    @(negedge clk); clr_a = 1'b0;
    check("a_timeout_cleared", 32'(to_a), 32'd0);

    // A: asynchronous reset during READ, then a fresh average
    feed_a = {16'hF000, 16'hF000, 16'hF000};
    r = cv_rises_a;
    wait_rises(1'b1, r + 3, 400, "a_three_starts");
    n = 0;
    do begin @(posedge clk); #1; n++; end while (rd_n_a && n < 40);
    check("a_reached_read", 32'(rd_n_a), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("a_async_rd_n", 32'(rd_n_a), 32'd1);
    check("a_async_convst", 32'(convst_a), 32'd0);
    check("a_async_sample", 32'(sample_a), 32'd0);
    check("a_async_valid", 32'(valid_a), 32'd0);
    @(negedge clk); reset = 1'b1;
    feed_a = {16'h0100, 16'h0200, 16'h0300, 16'h0400};
    exp_a.push_back(16'h0280);
    wait_exp(1'b1, 600, "a_fresh_average");
    check("a_final_overrun", 32'(ovr_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
